// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state type, digit constants and the overflow-limit helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OP,
        DONE
    } state_t;

    localparam int unsigned      DIGIT_W    = 4;
    localparam logic [3:0]       BCD_NINE   = 4'd9;
    localparam logic [3:0]       ADJ_THRESH = 4'd5;

    // Largest value representable in 'digits' decimal digits (10^digits - 1).
    function automatic int unsigned max_bcd_value(input int unsigned digits);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble correction: adds 3 to any digit of 5 or more
// so that the following left shift carries correctly into the next digit.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    // Inputs never exceed 9, so the 4-bit sum cannot wrap.
    assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit + DIGIT_W'(3)) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with start/ready/done handshake.
// bcd_out/overflow are held between conversions so the display never sees partial results.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    output logic                      ready,
    output logic                      done_tick,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                      overflow
);

    localparam int          BCD_W    = DIGIT_W * DIGITS;
    localparam int          CNT_W    = $clog2(BIN_W + 1);
    localparam int unsigned MAX_VAL  = max_bcd_value(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_t             r_state;
    logic [BIN_W-1:0]   r_bin_shift;
    logic [BCD_W-1:0]   r_bcd_work;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_bcd_next;
    logic [BCD_W-1:0]   w_all_nines;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .i_digit (r_bcd_work[g*DIGIT_W +: DIGIT_W]),
            .o_digit (w_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Corrected digits shifted left; the binary MSB enters the ones digit and
    // the top bit falls off (only nonzero when the input overflowed).
    assign w_bcd_next  = {w_adj[BCD_W-2:0], r_bin_shift[BIN_W-1]};
    assign w_all_nines = {DIGITS{BCD_NINE}};

    // NOTE: every register below is updated with <= so all reads in this block
    // see the pre-edge values, which is what the shift/adjust pipeline relies on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bin_shift <= '0;
            r_bcd_work  <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            ready       <= 1'b1;
            done_tick   <= 1'b0;
            bcd_out     <= '0;
            overflow    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin_shift <= bin_in;
                        r_bcd_work  <= '0;
                        r_cnt       <= CNT_LOAD;
                        r_ovf       <= (32'(bin_in) > MAX_VAL);
                        ready       <= 1'b0;
                        r_state     <= OP;
                    end
                end

                OP: begin
                    r_bcd_work  <= w_bcd_next;
                    r_bin_shift <= r_bin_shift << 1;
                    r_cnt       <= r_cnt - 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        // Result is published on the same edge that enters DONE.
                        bcd_out   <= r_ovf ? w_all_nines : w_bcd_next;
                        overflow  <= r_ovf;
                        done_tick <= 1'b1;
                        r_state   <= DONE;
                    end
                end

                DONE: begin
                    done_tick <= 1'b0;
                    ready     <= 1'b1;
                    r_state   <= IDLE;
                end

                default: begin
                    done_tick <= 1'b0;
                    ready     <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule
